alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage_if.sv | 35 +++
 rtl/alu_operand_stage.sv | 96 +++++++++
 tb/tb_alu_operand_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Bundle of the decode-side handshake, write-back port and ALU-side operand bundle.
// master = upstream/driver side, slave = the operand stage.
interface alu_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            In_valid;
    logic            In_ready;
    logic [4:0]      Rs_addr;
    logic [4:0]      Rt_addr;
    logic [4:0]      Rd_addr;
    logic [4:0]      Shamt_in;
    logic [1:0]      Funct_in;
    logic            Wb_en;
    logic [4:0]      Wb_addr;
    logic [XLEN-1:0] Wb_data;
    logic            Out_valid;
    logic            Out_ready;
    logic [XLEN-1:0] Src_1;
    logic [XLEN-1:0] Src_2;
    logic [4:0]      Shamt;
    logic [1:0]      Funct;
    logic [4:0]      Dest_addr;

    modport master (
        output In_valid, Rs_addr, Rt_addr, Rd_addr, Shamt_in, Funct_in,
        output Wb_en, Wb_addr, Wb_data, Out_ready,
        input  In_ready, Out_valid, Src_1, Src_2, Shamt, Funct, Dest_addr
    );

    modport slave (
        input  In_valid, Rs_addr, Rt_addr, Rd_addr, Shamt_in, Funct_in,
        input  Wb_en, Wb_addr, Wb_data, Out_ready,
        output In_ready, Out_valid, Src_1, Src_2, Shamt, Funct, Dest_addr
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand fetch stage: register file with write-back bypass, per-register busy
// scoreboard for hazard stalls, and a one-entry registered bundle toward the ALU.
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic clk,
    input logic rst_n,
    alu_operand_stage_if.slave bus
);
    // Handshakes (both sides): a beat moves on a rising edge where valid and
    // ready are both 1; a valid offer keeps its payload until it moves.
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    logic            wb_write;
    logic            rs_hazard;
    logic            rt_hazard;
    logic            rd_hazard;
    logic            hazard;
    logic            xfer;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    assign wb_write = bus.Wb_en && (bus.Wb_addr != 5'd0);

    // Register 0 reads as zero regardless of array contents.
    function automatic logic [XLEN-1:0] read_src(input logic [4:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (addr != 5'd0) begin
            if (wb_write && (bus.Wb_addr == addr))
                val = bus.Wb_data;
            else
                val = regs[addr];
        end
        return val;
    endfunction

    function automatic logic busy_now(input logic [4:0] addr);
        return busy[addr] && !(bus.Wb_en && (bus.Wb_addr == addr));
    endfunction

    always_comb begin
        rs_val    = read_src(bus.Rs_addr);
        rt_val    = read_src(bus.Rt_addr);
        rs_hazard = busy_now(bus.Rs_addr);
        rt_hazard = busy_now(bus.Rt_addr);
        rd_hazard = (bus.Rd_addr != 5'd0) && busy_now(bus.Rd_addr);
        hazard    = rs_hazard || rt_hazard || rd_hazard;
    end

    assign bus.In_ready = (!bus.Out_valid || bus.Out_ready) && !hazard;
    assign xfer         = bus.In_valid && bus.In_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_write) begin
            regs[bus.Wb_addr] <= bus.Wb_data;
        end
    end

    // Clear is applied first so a same-cycle set on the same register wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (bus.Wb_en)
                busy[bus.Wb_addr] <= 1'b0;
            if (xfer && (bus.Rd_addr != 5'd0))
                busy[bus.Rd_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Out_valid <= 1'b0;
            bus.Src_1     <= '0;
            bus.Src_2     <= '0;
            bus.Shamt     <= '0;
            bus.Funct     <= '0;
            bus.Dest_addr <= '0;
        end else if (xfer) begin
            bus.Out_valid <= 1'b1;
            bus.Src_1     <= rs_val;
            bus.Src_2     <= rt_val;
            bus.Shamt     <= bus.Shamt_in;
            bus.Funct     <= bus.Funct_in;
            bus.Dest_addr <= bus.Rd_addr;
        end else if (bus.Out_valid && bus.Out_ready) begin
            bus.Out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against a cycle-level
// register/scoreboard model built from plain arrays.
module tb_alu_operand_stage;
    logic clk;
    logic rst_n;

    alu_operand_stage_if #(.XLEN(32)) bus ();

    alu_operand_stage #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          m_ov;
    logic [31:0] m_src1, m_src2;
    logic [4:0]  m_shamt, m_dest;
    logic [1:0]  m_funct;
    bit          exp_rdy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_ov = 0; m_src1 = '0; m_src2 = '0; m_shamt = '0; m_dest = '0; m_funct = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit wbe,
                                           input logic [4:0] wba, input logic [31:0] wbd);
        if (a == 0) return 32'h0;
        if (wbe && wba == a) return wbd;
        return m_reg[a];
    endfunction

    function automatic bit m_blocked(input logic [4:0] a, input bit wbe, input logic [4:0] wba);
        return m_busy[a] && !(wbe && wba == a);
    endfunction

    task automatic check_outputs();
        check_val("out_valid", bus.Out_valid, m_ov);
        check_val("src_1",     bus.Src_1,     m_src1);
        check_val("src_2",     bus.Src_2,     m_src2);
        check_val("shamt",     bus.Shamt,     m_shamt);
        check_val("funct",     bus.Funct,     m_funct);
        check_val("dest_addr", bus.Dest_addr, m_dest);
    endtask

    task automatic drive(input bit iv, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [1:0] fn,
                         input bit wbe, input logic [4:0] wba, input logic [31:0] wbd,
                         input bit ordy);
        bus.In_valid = iv;  bus.Rs_addr = rs; bus.Rt_addr = rt; bus.Rd_addr = rd;
        bus.Shamt_in = sh;  bus.Funct_in = fn;
        bus.Wb_en = wbe;    bus.Wb_addr = wba; bus.Wb_data = wbd; bus.Out_ready = ordy;
    endtask

    // One clock: drive at negedge, check ready, advance model at posedge, check bundle.
    task automatic cycle(input bit iv, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [1:0] fn,
                         input bit wbe, input logic [4:0] wba, input logic [31:0] wbd,
                         input bit ordy);
        bit hz, xf;
        @(negedge clk);
        drive(iv, rs, rt, rd, sh, fn, wbe, wba, wbd, ordy);
        #1;
        hz = m_blocked(rs, wbe, wba) || m_blocked(rt, wbe, wba) ||
             (rd != 0 && m_blocked(rd, wbe, wba));
        exp_rdy = (!m_ov || ordy) && !hz;
        check_val("in_ready", bus.In_ready, exp_rdy);
        xf = iv && exp_rdy;
        @(posedge clk);
        if (xf) begin
            m_src1 = m_read(rs, wbe, wba, wbd);
            m_src2 = m_read(rt, wbe, wba, wbd);
            m_shamt = sh; m_funct = fn; m_dest = rd; m_ov = 1;
        end else if (m_ov && ordy) begin
            m_ov = 0;
        end
        if (wbe && wba != 0) m_reg[wba] = wbd;
        if (wbe) m_busy[wba] = 0;
        if (xf && rd != 0) m_busy[rd] = 1;
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_in_ready", bus.In_ready, 1);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Issue into r3; r3 becomes busy.
        cycle(1, 0, 0, 3, 0, 2'b00, 0, 0, 0, 1);
        check_val("issue_dest3", bus.Dest_addr, 3);
        // Same-cycle write-back to r5 is bypassed.
        cycle(1, 5, 0, 0, 0, 2'b01, 1, 5, 32'hAA, 1);
        check_val("bypass_aa", bus.Src_1, 32'hAA);
        cycle(1, 5, 5, 0, 1, 2'b11, 0, 0, 0, 1);
        check_val("read_r5", bus.Src_2, 32'hAA);
        // Rs=3 stalls until r3 write-back, which releases in the same cycle.
        cycle(1, 3, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        check_val("stall_r3", exp_rdy, 0);
        cycle(1, 3, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        cycle(1, 3, 0, 0, 0, 2'b00, 1, 3, 32'h1234, 1);
        check_val("release_r3", bus.Src_1, 32'h1234);
        // Backpressure: bundle A held for 3 cycles, even when its source is rewritten.
        cycle(1, 5, 3, 0, 4, 2'b10, 0, 0, 0, 1);
        cycle(1, 3, 5, 9, 7, 2'b01, 0, 0, 0, 0);
        cycle(1, 3, 5, 9, 7, 2'b01, 1, 5, 32'hBEEF, 0);
        cycle(1, 3, 5, 9, 7, 2'b01, 0, 0, 0, 0);
        check_val("held_src1", bus.Src_1, 32'hAA);
        cycle(1, 3, 5, 9, 7, 2'b01, 0, 0, 0, 1);
        check_val("no_bubble", bus.Src_2, 32'hBEEF);
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 32'h9, 1);
        // Writes to r0 are dropped; set wins over a same-cycle clear on r7.
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1);
        cycle(1, 0, 0, 7, 0, 2'b00, 1, 7, 32'h55, 1);
        check_val("r0_zero", bus.Src_1, 0);
        cycle(1, 7, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        check_val("busy7_set", exp_rdy, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 32'h77, 1);

        // Asynchronous reset mid-cycle with a held bundle and busy r4.
        cycle(1, 5, 0, 4, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_out_valid", bus.Out_valid, 0);
        check_val("async_src_1", bus.Src_1, 0);
        check_val("async_busy4", bus.In_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 9) < 7,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom), 2'($urandom),
                  $urandom_range(0, 9) < 5, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
